// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the RISC-V memory stage: IDLE/WAIT/RESP handshake, byte-lane stores, extended loads.
// Optional access-fault checking is enabled by defining DMEM_ERR_EN.
module riscv_dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   logic [3:0]  r_wcnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_size;
   logic        r_uns;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_we;
   logic [31:0]   w_addr;
   logic [31:0]   w_wdata;
   logic [1:0]    w_size;
   logic          w_uns;
   logic [AW-1:0] w_idx;
   logic [1:0]    w_ofs;
   logic          w_err;
   logic [3:0]    w_be;
   logic [31:0]   w_wword;
   logic [31:0]   w_rword;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;
   logic [31:0]   w_rsp_data;

   assign w_accept     = req_valid && r_req_ready && (r_state == S_IDLE);
   assign w_enter_resp = ((r_state == S_IDLE) && w_accept && (WAIT_STATES == 0)) ||
                         ((r_state == S_WAIT) && (r_wcnt == 4'd0));

   // With no wait states RESP is entered on the acceptance edge, so the live request fields are used directly
   always_comb begin
      w_we    = r_we;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_size  = r_size;
      w_uns   = r_uns;
      if (r_state == S_IDLE) begin
         w_we    = req_we;
         w_addr  = req_addr;
         w_wdata = req_wdata;
         w_size  = req_size;
         w_uns   = req_unsigned;
      end
   end

   always_comb begin
      w_idx = w_addr[AW+1:2];
      w_ofs = w_addr[1:0];
`ifdef DMEM_ERR_EN
      w_err = ((w_size == 2'b01) && w_ofs[0]) ||
              ((w_size == 2'b10) && (w_ofs != 2'b00)) ||
              (w_size == 2'b11) ||
              (|w_addr[31:AW+2]);
`else
      w_err = 1'b0;
`endif
   end

   always_comb begin
      w_be    = 4'b1111;
      w_wword = w_wdata;
      case (w_size)
         2'b00: begin
            w_be    = 4'b0001 << w_ofs;
            w_wword = {4{w_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = w_ofs[1] ? 4'b1100 : 4'b0011;
            w_wword = {2{w_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wword = w_wdata;
         end
      endcase
   end

   always_comb begin
      w_rword = r_mem[w_idx];
      w_byte  = w_rword[{w_ofs, 3'b000} +: 8];
      w_half  = w_rword[{w_ofs[1], 4'b0000} +: 16];
      case (w_size)
         2'b00:   w_load = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = w_rword;
      endcase
      w_rsp_data = (w_we || w_err) ? '0 : w_load;
   end

   // Memory has no reset; a held reset blocks the write so an abandoned store leaves no trace
   always_ff @(posedge clk) begin
      if (reset && w_enter_resp && w_we && !w_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wword[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_wcnt      <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req_ready <= 1'b1;
               if (w_accept) begin
                  r_we        <= req_we;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_size      <= req_size;
                  r_uns       <= req_unsigned;
                  r_req_ready <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= w_rsp_data;
                     r_rsp_err   <= w_err;
                  end else begin
                     r_state <= S_WAIT;
                     r_wcnt  <= WS - 4'd1;
                  end
               end
            end
            S_WAIT: begin
               if (r_wcnt == 4'd0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= w_rsp_data;
                  r_rsp_err   <= w_err;
               end else begin
                  r_wcnt <= r_wcnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Scoreboard bench for riscv_dmem_responder: instance A (1 wait state) and instance B (0 wait states).
// Expectations for fault handling follow DMEM_ERR_EN as defined for the build.
module tb_riscv_dmem_responder;

   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        rsp_ready;
   logic        sel;

   logic        a_req_ready, a_rsp_valid, a_rsp_err;
   logic [31:0] a_rsp_rdata;
   logic        b_req_ready, b_rsp_valid, b_rsp_err;
   logic [31:0] b_rsp_rdata;

   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rsp_rdata;

   riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid && !sel), .req_ready(a_req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid && sel), .req_ready(b_req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   assign m_req_ready = sel ? b_req_ready : a_req_ready;
   assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
   assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          ws;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   mon_en  = 1'b0;
   bit   pend    = 1'b0;
   int   first_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // Monitor: response checked on handshake; latency measured from the first cycle rsp_valid is seen
   always @(negedge clk) begin
      if (mon_en) begin
         if (m_rsp_valid) begin
            if (!pend) begin
               pend      = 1'b1;
               first_cyc = cyc;
            end
            if (rsp_ready) begin
               if (sb.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_rsp: got rdata 0x%08h with empty scoreboard", m_rsp_rdata);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk({e.name, "_rdata"}, m_rsp_rdata, e.rdata);
                  chk({e.name, "_err"}, 32'(m_rsp_err), 32'(e.err));
                  chk({e.name, "_latency"}, 32'(first_cyc), 32'(e.acc + e.ws));
               end
               pend = 1'b0;
            end
         end else begin
            pend = 1'b0;
            chk("idle_rsp_zero", {m_rsp_rdata[31:1], m_rsp_rdata[0] | m_rsp_err}, 32'h0);
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the acceptance edge
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_d, input logic exp_e, input bit push,
                        input string nm, output int acc);
      int n;
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
      req_valid    = 1'b1;
      n = 0;
      while (!m_req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!m_req_ready) begin
         n_total++;
         $display("FAIL %s_accept_timeout: got req_ready 0 expected 1", nm);
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      if (push) sb.push_back('{exp_d, exp_e, acc, sel ? 0 : 1, nm});
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((sb.size() != 0 || pend) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0 || pend) begin
         n_total++;
         $display("FAIL %s_drain_timeout: got %0d pending expected 0", nm, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int a0, a1, a2, n;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = 2'b10; req_unsigned = 1'b0; rsp_ready = 1'b1; sel = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(a_req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
      chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(a_rsp_err), 32'h0);
      reset = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      chk("rel_req_ready", 32'(a_req_ready), 32'h1);

      // Word store/load round trip
      issue(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, "st_w10", a0);
      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, "ld_w10", a0);
      drain("word");

      // Byte and half lanes in word 0x20
      issue(1'b1, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, "st_w20", a0);
      issue(1'b1, 32'h21, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, "st_b21", a0);
      issue(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 1'b1, "ld_b21s", a0);
      issue(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0, 1'b1, "ld_b21u", a0);
      issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h00008000, 1'b0, 1'b1, "ld_w20a", a0);
      issue(1'b1, 32'h22, 32'h0000BEEF, 2'b01, 1'b0, 32'h0, 1'b0, 1'b1, "st_h22", a0);
      issue(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b1, "ld_h22s", a0);
      issue(1'b0, 32'h20, 32'h0, 2'b01, 1'b1, 32'h00008000, 1'b0, 1'b1, "ld_h20u", a0);
      issue(1'b0, 32'h23, 32'h0, 2'b00, 1'b1, 32'h000000BE, 1'b0, 1'b1, "ld_b23u", a0);
      issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hBEEF8000, 1'b0, 1'b1, "ld_w20b", a0);
      drain("lanes");

      // Back-pressure: response held stable, no turnaround in the handshake cycle
      rsp_ready = 1'b0;
      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, "hold_ld", a0);
      n = 0;
      while (!a_rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(a_rsp_valid), 32'h1);
         chk("hold_rdata", a_rsp_rdata, 32'hDEADBEEF);
         chk("hold_req_ready", 32'(a_req_ready), 32'h0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      chk("hs_cycle_req_ready", 32'(a_req_ready), 32'h0);
      @(posedge clk); #1;
      chk("post_hs_req_ready", 32'(a_req_ready), 32'h1);
      drain("hold");

      // Fault handling or wrap-around, depending on build
      issue(1'b1, 32'h0, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, "st_w0", a0);
`ifdef DMEM_ERR_EN
      issue(1'b0, 32'h3, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1'b1, "ld_h3_err", a0);
      issue(1'b1, DEPTH * 4, 32'hA5A5A5A5, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, "st_oob_err", a0);
      issue(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0, 1'b1, "ld_w0_kept", a0);
      issue(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1'b1, "ld_sz3_err", a0);
`else
      issue(1'b0, 32'h3, 32'h0, 2'b01, 1'b0, 32'h00001111, 1'b0, 1'b1, "ld_h3_nofault", a0);
      issue(1'b1, DEPTH * 4, 32'hA5A5A5A5, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, "st_oob_wrap", a0);
      issue(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1, "ld_w0_wrapped", a0);
      issue(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1, "ld_sz3_word", a0);
`endif
      drain("fault");

      // Reset during the wait state of a store abandons it
      issue(1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, "st_w40", a0);
      drain("pre_reset");
      issue(1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, "st_w40_abort", a0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_req_ready", 32'(a_req_ready), 32'h0);
      chk("midrst_rsp_valid", 32'(a_rsp_valid), 32'h0);
      chk("midrst_rsp_rdata", a_rsp_rdata, 32'h0);
      chk("midrst_rsp_err", 32'(a_rsp_err), 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_rel_ready", 32'(a_req_ready), 32'h1);
      issue(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, "ld_w40_prior", a0);
      drain("midrst");

      // Zero wait states: one transaction every two cycles
      sel = 1'b1;
      @(posedge clk); #1;
      issue(1'b1, 32'h8, 32'h01020304, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, "b_st_w8", a0);
      issue(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0, 1'b1, "b_ld_w8", a1);
      issue(1'b0, 32'hB, 32'h0, 2'b00, 1'b1, 32'h00000001, 1'b0, 1'b1, "b_ld_bB", a2);
      chk("b_spacing_1", 32'(a1 - a0), 32'd2);
      chk("b_spacing_2", 32'(a2 - a1), 32'd2);
      drain("ws0");

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/riscv_dmem_responder.md
RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024, number of 32-bit data memory words (power of two, 16..65536).
REQ-002 Parameter: WAIT_STATES, default 1, extra cycles between request acceptance and response (0..15).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 Port: req_valid  input  1  datapath memory-stage request present.
REQ-006 Port: req_ready  output  1  responder can accept a request.
REQ-007 Port: req_we  input  1  1 = store, 0 = load.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  store data, right-aligned.
REQ-010 Port: req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 Port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 Port: rsp_valid  output  1  response present.
REQ-013 Port: rsp_ready  input  1  datapath accepts response.
REQ-014 Port: rsp_rdata  output  32  load result, extended to 32 bits.
REQ-015 Port: rsp_err  output  1  access fault flag.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance on req_valid && req_ready; all req_* fields captured in registers at that edge; inputs ignored afterwards.
REQ-018 IDLE -> RESP if WAIT_STATES==0, else IDLE -> WAIT; WAIT counts WAIT_STATES cycles then -> RESP.
REQ-019 rsp_valid SHALL assert exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-020 Store SHALL update memory at the edge entering RESP, writing only lanes selected by size and addr[1:0] (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all four).
REQ-021 Load: data read at the edge entering RESP; selected byte/half shifted to bits [7:0]/[15:0] and sign/zero extended per req_unsigned.
REQ-022 Store response: rsp_rdata = 0, rsp_err per error rules.
REQ-023 In RESP, rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_valid && rsp_ready; then -> IDLE.
REQ-024 No same-cycle turnaround: req_ready is 0 in the response-handshake cycle and 1 on the following cycle.
REQ-025 Address word index = addr[31:2]; rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid is 0.
REQ-026 A load from a word stored earlier SHALL return the stored value (no stale read); load of same address in back-to-back transactions sees the prior store.

Reset
REQ-027 When reset==0 at a clock edge: state -> IDLE, wait counter 0, req_ready 0 during reset then 1 on first edge after release, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-028 Reset mid-transaction abandons it; an in-flight store not yet in RESP SHALL not modify memory.
REQ-029 Memory contents are not cleared by reset.

Configuration
REQ-030 Macro DMEM_ERR_EN defined: rsp_err=1 for misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0), req_size=11, or addr[31:2] >= DEPTH_WORDS; faulted store writes nothing, faulted load returns rsp_rdata=0; timing unchanged.
REQ-031 Macro DMEM_ERR_EN undefined: rsp_err tied 0; size 11 treated as word; misaligned low bits ignored (half uses addr[1], word uses none); word index wraps modulo DEPTH_WORDS.

Verification
REQ-032 WAIT_STATES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each acceptance.
REQ-033 Store byte 0x80 @0x21 over word 0x00000000 @0x20; load byte signed @0x21 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x20 -> 0x00008000.
REQ-034 Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready 0; release -> req_ready 1 one cycle after handshake.
REQ-035 DMEM_ERR_EN defined: load half @0x3 -> rsp_err 1, rsp_rdata 0; store word @ (DEPTH_WORDS*4) -> rsp_err 1, word 0 unchanged. Undefined: same store wraps and overwrites word 0.
REQ-036 Assert reset=0 while in WAIT of a store 0x12345678 @0x40 -> all outputs reset values next edge; subsequent load @0x40 returns prior contents, not 0x12345678.
REQ-037 WAIT_STATES=0: back-to-back accepted requests with rsp_ready=1 -> one transaction per 2 cycles, rsp_valid 1 cycle after acceptance.
